// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator: registered syncs, active flag, coordinates and line/frame strobes.
// Optional build macro VGA_FRAME_CNT_EN adds an 8-bit frame counter; otherwise frame_cnt is tied to 0.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    output logic       hsync,
    output logic       vsync,
    output logic       video_active,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
            $error("vga_timing_gen: raster totals must not exceed 1024");
        end
    endgenerate

    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        SYNC_ON = 1'(SYNC_POL);

    logic [9:0]  nx, ny;
    logic [10:0] nx_w, ny_w;
    logic        x_wrap, new_frame, hs_on, vs_on;

    // Outputs are decoded from the next counter values so everything updates in the same cycle.
    always_comb begin
        x_wrap    = (pix_x == H_LAST);
        new_frame = x_wrap && (pix_y == V_LAST);
        nx        = x_wrap ? 10'd0 : pix_x + 10'd1;
        ny        = pix_y;
        if (x_wrap) begin
            ny = (pix_y == V_LAST) ? 10'd0 : pix_y + 10'd1;
        end
        nx_w  = {1'b0, nx};
        ny_w  = {1'b0, ny};
        hs_on = (nx_w >= HS_BEG) && (nx_w < HS_END);
        vs_on = (ny_w >= VS_BEG) && (ny_w < VS_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_x        <= H_LAST;
            pix_y        <= V_LAST;
            video_active <= 1'b0;
            hsync        <= ~SYNC_ON;
            vsync        <= ~SYNC_ON;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else if (ena) begin
            pix_x        <= nx;
            pix_y        <= ny;
            video_active <= (nx_w < H_VIS) && (ny_w < V_VIS);
            hsync        <= hs_on ? SYNC_ON : ~SYNC_ON;
            vsync        <= vs_on ? SYNC_ON : ~SYNC_ON;
            line_start   <= x_wrap;
            frame_start  <= new_frame;
        end else begin
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 8'h00;
        end else if (ena && new_frame) begin
            frame_cnt_q <= frame_cnt_q + 8'h01;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a reduced raster (16x12 totals) so full frames are short.
module tb_vga_timing_gen;

    localparam int HA = 8, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 6, VFP = 1, VS = 2, VBP = 3;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       hsync, vsync, video_active, line_start, frame_start;
    logic [9:0] pix_x, pix_y;
    logic [7:0] frame_cnt;

    int n_cmp = 0;
    int n_err = 0;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .hsync(hsync), .vsync(vsync), .video_active(video_active),
        .pix_x(pix_x), .pix_y(pix_y),
        .line_start(line_start), .frame_start(frame_start),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic goto_xy(input int tx, input int ty);
        int budget;
        budget = 0;
        while (!(pix_x == 10'(tx) && pix_y == 10'(ty)) && budget < 2 * HT * VT) begin
            step();
            budget++;
        end
        chk("goto_reached", {31'd0, (budget < 2 * HT * VT)}, 32'd1);
    endtask

    // Per-frame statistics
    int xy_bad, va_row0, hs_low_row0, hs_fall_x, hs_rise_x, va_total;
    int vs_low, vs_fall_x, vs_fall_y, ls_cnt, fs_cnt;
    logic prev_hs, prev_vs;
    // Gating / frame counter state
    int hold_bad, strobe_seen, fs_seen, fc_bad, budget;
    logic [9:0] hx, hy;
    logic hhs, hvs, hva;
    bit wrap_seen;

    initial begin
        // Reset held for 5 cycles
        repeat (5) step();
        chk("rst_pix_x", pix_x, HT - 1);
        chk("rst_pix_y", pix_y, VT - 1);
        chk("rst_video_active", video_active, 0);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_line_start", line_start, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_frame_cnt", frame_cnt, 0);

        rst_n = 1'b1;
        step();
        chk("first_pix_x", pix_x, 0);
        chk("first_pix_y", pix_y, 0);
        chk("first_video_active", video_active, 1);
        chk("first_line_start", line_start, 1);
        chk("first_frame_start", frame_start, 1);
        chk("first_hsync", hsync, 1);
`ifdef VGA_FRAME_CNT_EN
        chk("first_frame_cnt", frame_cnt, 1);
`else
        chk("first_frame_cnt", frame_cnt, 0);
`endif

        // Full frame walk from (0,0)
        xy_bad = 0; va_row0 = 0; hs_low_row0 = 0; hs_fall_x = -1; hs_rise_x = -1;
        va_total = 0; vs_low = 0; vs_fall_x = -1; vs_fall_y = -1; ls_cnt = 0; fs_cnt = 0;
        prev_hs = 1'b1; prev_vs = 1'b1;
        for (int i = 0; i < HT * VT; i++) begin
            if (pix_x != 10'(i % HT) || pix_y != 10'(i / HT)) xy_bad++;
            if (video_active) va_total++;
            if (i < HT) begin
                if (video_active) va_row0++;
                if (!hsync) hs_low_row0++;
                if (prev_hs && !hsync && hs_fall_x < 0) hs_fall_x = int'(pix_x);
                if (!prev_hs && hsync && hs_rise_x < 0) hs_rise_x = int'(pix_x);
            end
            if (!vsync) vs_low++;
            if (prev_vs && !vsync && vs_fall_y < 0) begin
                vs_fall_x = int'(pix_x);
                vs_fall_y = int'(pix_y);
            end
            if (line_start) ls_cnt++;
            if (frame_start) fs_cnt++;
            if (frame_start && !line_start) xy_bad++;
            prev_hs = hsync;
            prev_vs = vsync;
            step();
        end
        chk("raster_sequence", xy_bad, 0);
        chk("row0_active_cycles", va_row0, HA);
        chk("row0_hsync_low", hs_low_row0, HS);
        chk("hsync_fall_x", hs_fall_x, HA + HFP);
        chk("hsync_rise_x", hs_rise_x, HA + HFP + HS);
        chk("frame_active_cycles", va_total, HA * VA);
        chk("vsync_low_cycles", vs_low, VS * HT);
        chk("vsync_fall_y", vs_fall_y, VA + VFP);
        chk("vsync_fall_x", vs_fall_x, 0);
        chk("line_start_per_frame", ls_cnt, VT);
        chk("frame_start_per_frame", fs_cnt, 1);
        chk("frame_period_fs", frame_start, 1);
        chk("frame_period_x", pix_x, 0);
        chk("frame_period_y", pix_y, 0);

        // Enable gating for 37 cycles at (5,3)
        goto_xy(5, 3);
        hx = pix_x; hy = pix_y; hhs = hsync; hvs = vsync; hva = video_active;
        ena = 1'b0;
        hold_bad = 0; strobe_seen = 0;
        repeat (37) begin
            step();
            if (pix_x !== hx || pix_y !== hy || hsync !== hhs || vsync !== hvs || video_active !== hva)
                hold_bad++;
            if (line_start || frame_start) strobe_seen++;
        end
        chk("gate_hold", hold_bad, 0);
        chk("gate_no_strobe", strobe_seen, 0);
        chk("gate_held_active", hva, 1);
        ena = 1'b1;
        step();
        chk("gate_resume_x", pix_x, 6);
        chk("gate_resume_y", pix_y, 3);

        // Asynchronous mid-frame reset while hsync is asserted
        goto_xy(10, 4);
        chk("pre_rst_hsync", hsync, 0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_x", pix_x, HT - 1);
        chk("async_rst_y", pix_y, VT - 1);
        chk("async_rst_hsync", hsync, 1);
        chk("async_rst_active", video_active, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("restart_x", pix_x, 0);
        chk("restart_y", pix_y, 0);
        chk("restart_fs", frame_start, 1);

        // Frame counter: 256 further frame_starts makes 257 since reset
        fs_seen = 1; fc_bad = 0; budget = 0; wrap_seen = 1'b0;
        while (fs_seen < 257 && budget < 260 * HT * VT) begin
            step();
            budget++;
            if (frame_start) begin
                fs_seen++;
                if (frame_cnt == 8'h00) wrap_seen = 1'b1;
            end
            if (frame_cnt !== 8'h00) fc_bad++;
        end
        chk("fc_budget", fs_seen, 257);
`ifdef VGA_FRAME_CNT_EN
        chk("fc_after_257", frame_cnt, 1);
        chk("fc_wrap_seen", {31'd0, wrap_seen}, 1);
`else
        chk("fc_tied_zero", fc_bad, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
